stream_arbiter_qos_rr: RTL and testbench
========================================

// Module: stream_arbiter_qos_rr
// PURPOSE
//  Packet-level N:1 stream arbiter with QoS priority, round-robin tie-break and anti-starvation aging.
//  Merges STREAM_COUNT valid/ready input streams onto one output stream.
//  Holds a grant for a whole packet, until the beat with last is accepted.
//  Sits in front of the shared egress link. Registered output stage, full throughput (1 beat/clk).
// PARAMETERS
//  T_DATA_WIDTH  8   data bus width
//  T_QOS__WIDTH  4   QoS field width; larger value = higher priority
//  STREAM_COUNT  4   number of input streams (>=2)
//  AGE_LIMIT     8   lost arbitrations before a waiting stream is boosted; 0 = aging disabled
//  T_ID___WIDTH  localparam = $clog2(STREAM_COUNT)
// PORTS
//  clk        in   1                          clock, all logic on posedge
//  rst_n      in   1                          asynchronous reset, active low
//  s_data_i   in   T_DATA_WIDTH x STREAM_COUNT  per-stream data (unpacked array)
//  s_qos_i    in   T_QOS__WIDTH x STREAM_COUNT  per-stream QoS, sampled at grant
//  s_last_i   in   STREAM_COUNT               per-stream last-beat flag
//  s_valid_i  in   STREAM_COUNT               per-stream valid
//  s_ready_o  out  STREAM_COUNT               per-stream ready, at most one bit high
//  m_data_o   out  T_DATA_WIDTH               output data
//  m_qos_o    out  T_QOS__WIDTH               QoS of the packet in flight
//  m_id_o     out  T_ID___WIDTH               index of the source stream
//  m_last_o   out  1                          output last-beat flag
//  m_valid_o  out  1                          output valid
//  m_ready_i  in   1                          downstream ready
// BEHAVIOUR
//  Reset (async, rst_n=0): m_valid_o=0, s_ready_o=0, m_data/qos/id/last_o=0; FSM=IDLE.
//   Also: rr_ptr=0, all age counters=0. Reset mid-packet drops the packet silently.
//  Handshake: a beat transfers when valid&&ready are high on the same posedge.
//   Once m_valid_o=1, all m_* outputs are held stable until m_ready_i=1.
//  FSM IDLE: if any s_valid_i is high, pick winner w (below), go BUSY on the next edge.
//   At that edge: latch gnt=w and gnt_qos=s_qos_i[w]; set age[w]=0.
//   Valid losers increment age (saturating at AGE_LIMIT). Set rr_ptr=(w+1) mod STREAM_COUNT.
//  FSM BUSY: s_ready_o[gnt] = !m_valid_o || m_ready_i (combinational); all other bits are 0.
//   On an accepted input beat: load the output register with s_data_i[gnt], s_last_i[gnt],
//   gnt_qos and gnt; set m_valid_o=1.
//   On an accepted beat with s_last_i[gnt]=1: go IDLE.
//   When m_valid_o=1, m_ready_i=1 and no new beat arrives: m_valid_o goes to 0.
//  Winner: effective priority = {aged, qos}; aged = (AGE_LIMIT!=0 && age==AGE_LIMIT).
//   The highest priority among valid streams wins.
//   Ties go to the first valid stream at or after rr_ptr, in cyclic index order.
//  Latency: s_valid_i high in IDLE at edge N -> s_ready_o high in cycle N+1 (1 idle cycle per packet).
//   -> m_valid_o high after edge N+1 if the beat was accepted there.
//  Ungranted streams are never dropped and never reordered. s_valid_i falling mid-packet inserts bubbles only.
//  QoS changes on s_qos_i during a packet do not affect m_qos_o.
//  Single-beat packet (last on the first beat) is legal: BUSY lasts 1 cycle.
//  Index arithmetic wraps mod STREAM_COUNT. For non-power-of-2 counts, rr_ptr never reaches >=STREAM_COUNT.
// TESTING
//  1 S0 qos=3, S1 qos=7, both valid with 3-beat packets -> m_id_o=1 for 3 beats (last on beat 3),
//    then m_id_o=0 for 3 beats; m_qos_o=7 then 3.
//  2 4 streams, equal qos=4, continuously valid single-beat packets, m_ready_i=1 -> m_id_o sequence 0,1,2,3,0,1.
//  3 8-beat packet, m_ready_i held low 5 cycles after beat 2 -> m_data_o stable, s_ready_o=0;
//    all 8 beats appear exactly once, in order.
//  4 AGE_LIMIT=2, S1 qos=9 back-to-back packets, S0 qos=1 valid -> S0 granted on the 3rd arbitration, then age[0]=0.
//  5 rst_n low for 1 cycle during beat 4 of a packet -> m_valid_o=0 and s_ready_o=0 immediately;
//    the next grant follows rr_ptr=0 rules.
//  6 Single stream, 8-beat packet, m_ready_i=1 -> 8 output beats on 8 consecutive cycles, m_last_o=1 only on beat 8.

Source files
------------

// File: rtl/stream_arbiter_qos_rr.sv
// stream_arbiter_qos_rr: packet-level N:1 valid/ready stream arbiter.
// QoS priority, round-robin tie-break, aging boost, registered output stage.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_data_i[N]         per-stream data
//   s_qos_i[N]          per-stream QoS, sampled when a packet is granted
//   s_last_i[N]         per-stream last-beat flag
//   s_valid_i[N]        per-stream valid
//   s_ready_o[N]        per-stream ready, at most one bit high
//   m_data_o            output data
//   m_qos_o             QoS of the packet in flight
//   m_id_o              source stream index of the packet in flight
//   m_last_o            output last-beat flag
//   m_valid_o           output valid
//   m_ready_i           downstream ready
module stream_arbiter_qos_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 4,
    parameter int AGE_LIMIT    = 8,
    localparam int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT],
    input  logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT],
    input  logic [STREAM_COUNT-1:0] s_last_i,
    input  logic [STREAM_COUNT-1:0] s_valid_i,
    output logic [STREAM_COUNT-1:0] s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_QOS__WIDTH-1:0] m_qos_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int AGE_W = (AGE_LIMIT < 2) ? 1 : $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
    localparam int PW = T_QOS__WIDTH + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                  state_q;
    logic [T_ID___WIDTH-1:0] gnt_q;
    logic [T_QOS__WIDTH-1:0] gnt_qos_q;
    logic [T_ID___WIDTH-1:0] rr_ptr_q;
    logic [AGE_W-1:0]        age_q [STREAM_COUNT];

    logic [T_DATA_WIDTH-1:0] m_data_q;
    logic [T_QOS__WIDTH-1:0] m_qos_q;
    logic [T_ID___WIDTH-1:0] m_id_q;
    logic                    m_last_q;
    logic                    m_valid_q;

    logic [T_ID___WIDTH-1:0] cand [STREAM_COUNT];
    logic [PW-1:0]           prio [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] aged;
    logic [T_ID___WIDTH-1:0] gnt_d;
    logic [PW-1:0]           best_prio;
    logic                    found;
    logic                    out_free;
    logic                    beat_acc;

    // (base + k) mod STREAM_COUNT, valid for base < STREAM_COUNT and k <= STREAM_COUNT
    function automatic logic [T_ID___WIDTH-1:0] rot_idx(
        input logic [T_ID___WIDTH-1:0] base,
        input int                      k
    );
        int sum;
        sum = int'(base) + k;
        if (sum >= STREAM_COUNT) begin
            sum = sum - STREAM_COUNT;
        end
        return T_ID___WIDTH'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) begin
            aged[i] = (AGE_LIMIT != 0) && (age_q[i] == AGE_MAX);
        end
    end

    // Candidates in cyclic order starting at rr_ptr; the scan keeps the
    // first of equal-priority streams, which gives the round-robin tie-break.
    always_comb begin
        for (int k = 0; k < STREAM_COUNT; k++) begin
            cand[k] = rot_idx(rr_ptr_q, k);
            prio[k] = {aged[cand[k]], s_qos_i[cand[k]]};
        end
    end

    always_comb begin
        found     = 1'b0;
        gnt_d     = rr_ptr_q;
        best_prio = '0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            if (s_valid_i[cand[k]] && (!found || prio[k] > best_prio)) begin
                found     = 1'b1;
                gnt_d     = cand[k];
                best_prio = prio[k];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !m_valid_q || m_ready_i;

    always_comb begin
        s_ready_o = '0;
        if (state_q == BUSY) begin
            s_ready_o[gnt_q] = out_free;
        end
    end

    assign beat_acc = (state_q == BUSY) && s_valid_i[gnt_q] && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_qos_q <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < STREAM_COUNT; i++) begin
                age_q[i] <= '0;
            end
            m_data_q  <= '0;
            m_qos_q   <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|s_valid_i) begin
                        state_q   <= BUSY;
                        gnt_q     <= gnt_d;
                        gnt_qos_q <= s_qos_i[gnt_d];
                        rr_ptr_q  <= rot_idx(gnt_d, 1);
                        for (int i = 0; i < STREAM_COUNT; i++) begin
                            if (T_ID___WIDTH'(i) == gnt_d) begin
                                age_q[i] <= '0;
                            end else if (s_valid_i[i] && age_q[i] != AGE_MAX) begin
                                age_q[i] <= age_q[i] + 1'b1;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (beat_acc && s_last_i[gnt_q]) begin
                        state_q <= IDLE;
                    end
                end
            endcase

            if (beat_acc) begin
                m_data_q  <= s_data_i[gnt_q];
                m_last_q  <= s_last_i[gnt_q];
                m_qos_q   <= gnt_qos_q;
                m_id_q    <= gnt_q;
                m_valid_q <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_data_o  = m_data_q;
    assign m_qos_o   = m_qos_q;
    assign m_id_o    = m_id_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_arbiter_qos_rr.sv
// tb_stream_arbiter_qos_rr: self-checking bench for stream_arbiter_qos_rr.
// Packet-order table vectors, corner sequences and random traffic vs a model.
module tb_stream_arbiter_qos_rr;

    localparam int NS   = 4;
    localparam int AGE  = 2;
    localparam int MAXP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data_i [NS];
    logic [3:0] s_qos_i  [NS];
    logic [3:0] s_last_i;
    logic [3:0] s_valid_i;
    logic [3:0] s_ready_o;
    logic [7:0] m_data_o;
    logic [3:0] m_qos_o;
    logic [1:0] m_id_o;
    logic       m_last_o;
    logic       m_valid_o;
    logic       m_ready_i;

    always #5 clk = ~clk;

    stream_arbiter_qos_rr #(
        .T_DATA_WIDTH(8),
        .T_QOS__WIDTH(4),
        .STREAM_COUNT(NS),
        .AGE_LIMIT   (AGE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data_i (s_data_i),
        .s_qos_i  (s_qos_i),
        .s_last_i (s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o (m_data_o),
        .m_qos_o  (m_qos_o),
        .m_id_o   (m_id_o),
        .m_last_o (m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i)
    );

    typedef struct packed {
        logic [3:0] qos;
        logic [7:0] len;
        logic [7:0] base;
    } pkt_t;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] qos;
        logic [7:0] data;
        logic       last;
    } beat_t;

    // Per-stream nibbles packed {S3,S2,S1,S0}; ids holds 2-bit grant order, first at LSB.
    typedef struct packed {
        logic [15:0] qos;
        logic [15:0] npk;
        logic [7:0]  len;
        logic [3:0]  nexp;
        logic [15:0] ids;
    } vec_t;

    pkt_t       pk [NS][MAXP];
    int         npk [NS];
    int         cur [NS];
    int         bidx [NS];
    bit         started [NS];
    beat_t      exp_q[$];
    logic [1:0] obs_ids[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         first_cyc;
    int         last_cyc;
    vec_t       vecs [6];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_pkts();
        for (int s = 0; s < NS; s++) begin
            npk[s] = 0;
            cur[s] = 0;
            bidx[s] = 0;
            started[s] = 1'b0;
        end
        exp_q.delete();
        obs_ids.delete();
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < NS; s++) begin
            s_data_i[s] = '0;
            s_qos_i[s] = '0;
        end
        s_valid_i = '0;
        s_last_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        m_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_pkts();
    endtask

    task automatic add_pkt(input int s, input logic [3:0] q, input int len);
        pk[s][npk[s]] = '{qos: q, len: 8'(len), base: 8'($urandom)};
        npk[s]++;
    endtask

    // Reference: every stream with a pending packet competes at each
    // arbitration; highest {aged,qos} wins, ties go cyclically from rr.
    task automatic model_build();
        int age [NS];
        int nxt [NS];
        int rr;
        int best;
        int bestp;
        int p;
        int s;
        beat_t b;
        rr = 0;
        for (int i = 0; i < NS; i++) begin
            age[i] = 0;
            nxt[i] = 0;
        end
        exp_q.delete();
        for (int a = 0; a < NS * MAXP; a++) begin
            best = -1;
            bestp = -1;
            for (int k = 0; k < NS; k++) begin
                s = (rr + k) % NS;
                if (nxt[s] < npk[s]) begin
                    p = int'(pk[s][nxt[s]].qos);
                    if (AGE != 0 && age[s] >= AGE) p = p + 16;
                    if (p > bestp) begin
                        best = s;
                        bestp = p;
                    end
                end
            end
            if (best < 0) break;
            for (int i = 0; i < NS; i++) begin
                if (i != best && nxt[i] < npk[i])
                    age[i] = (age[i] < AGE) ? age[i] + 1 : AGE;
            end
            age[best] = 0;
            rr = (best + 1) % NS;
            for (int bi = 0; bi < int'(pk[best][nxt[best]].len); bi++) begin
                b.id = 2'(best);
                b.qos = pk[best][nxt[best]].qos;
                b.data = pk[best][nxt[best]].base + 8'(bi);
                b.last = (bi == int'(pk[best][nxt[best]].len) - 1);
                exp_q.push_back(b);
            end
            nxt[best]++;
        end
    endtask

    // rmode: 0 random ready, 1 always ready, 2 stall 5 cycles after output beat 2.
    task automatic run(input int rmode, input int bub, input int max_cyc);
        int    cyc;
        int    nbeats;
        int    seen;
        int    stall;
        bit    hold;
        bit    pstart;
        beat_t held;
        beat_t cb;
        beat_t e;
        pkt_t  p;
        logic [3:0] acc;
        cyc = 0;
        seen = 0;
        stall = 0;
        hold = 1'b0;
        pstart = 1'b1;
        held = '0;
        first_cyc = -1;
        last_cyc = -1;
        nbeats = exp_q.size();
        obs_ids.delete();
        while (seen < nbeats && cyc < max_cyc) begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                if (cur[s] < npk[s]) begin
                    p = pk[s][cur[s]];
                    s_valid_i[s] = !(started[s] && ($urandom_range(0, 99) < bub));
                    s_data_i[s] = p.base + 8'(bidx[s]);
                    s_last_i[s] = (bidx[s] == int'(p.len) - 1);
                    s_qos_i[s] = started[s] ? 4'($urandom) : p.qos;
                end else begin
                    s_valid_i[s] = 1'b0;
                    s_data_i[s] = '0;
                    s_last_i[s] = 1'b0;
                    s_qos_i[s] = '0;
                end
            end
            if (rmode == 1) m_ready_i = 1'b1;
            else if (rmode == 2) begin
                m_ready_i = (stall == 0);
                if (stall > 0) stall--;
            end else m_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            acc = s_valid_i & s_ready_o;
            cmp("ready_onehot", 32'($onehot0(s_ready_o)), 32'd1);
            if (m_valid_o && !m_ready_i) cmp("ready_in_stall", 32'(s_ready_o), 32'd0);
            cb = {m_id_o, m_qos_o, m_data_o, m_last_o};
            if (hold) begin
                cmp("hold_valid", 32'(m_valid_o), 32'd1);
                cmp("hold_beat", 32'(cb), 32'(held));
            end
            hold = m_valid_o && !m_ready_i;
            held = cb;
            if (m_valid_o && m_ready_i) begin
                if (pstart) obs_ids.push_back(m_id_o);
                pstart = m_last_o;
                e = exp_q.pop_front();
                cmp("beat", 32'(cb), 32'(e));
                seen++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (rmode == 2 && seen == 2) stall = 5;
            end
            @(posedge clk);
            for (int s = 0; s < NS; s++) begin
                if (acc[s]) begin
                    bidx[s]++;
                    started[s] = 1'b1;
                    if (bidx[s] == int'(pk[s][cur[s]].len)) begin
                        cur[s]++;
                        bidx[s] = 0;
                        started[s] = 1'b0;
                    end
                end
            end
            cyc++;
        end
        cmp("beats_delivered", 32'(seen), 32'(nbeats));
        @(negedge clk);
        idle_inputs();
        m_ready_i = 1'b1;
        #1;
        cmp("idle_mvalid", 32'(m_valid_o), 32'd0);
        cmp("idle_sready", 32'(s_ready_o), 32'd0);
    endtask

    initial begin
        int got;
        int cyc;
        logic a;

        vecs[0] = '{qos: 16'h0073, npk: 16'h0011, len: 8'd3, nexp: 4'd2, ids: 16'h0001};
        vecs[1] = '{qos: 16'h4444, npk: 16'h2222, len: 8'd1, nexp: 4'd8, ids: 16'hE4E4};
        vecs[2] = '{qos: 16'h0091, npk: 16'h0042, len: 8'd2, nexp: 4'd6, ids: 16'h0145};
        vecs[3] = '{qos: 16'h1552, npk: 16'h1111, len: 8'd1, nexp: 4'd4, ids: 16'h00C9};
        vecs[4] = '{qos: 16'h6600, npk: 16'h1100, len: 8'd2, nexp: 4'd2, ids: 16'h000E};
        vecs[5] = '{qos: 16'h0000, npk: 16'h2002, len: 8'd1, nexp: 4'd4, ids: 16'h00CC};

        idle_inputs();
        m_ready_i = 1'b0;
        clear_pkts();
        @(negedge clk);
        #1;
        cmp("rst_mvalid", 32'(m_valid_o), 32'd0);
        cmp("rst_sready", 32'(s_ready_o), 32'd0);
        cmp("rst_mdata", 32'(m_data_o), 32'd0);
        cmp("rst_mqos", 32'(m_qos_o), 32'd0);
        cmp("rst_mid", 32'(m_id_o), 32'd0);
        cmp("rst_mlast", 32'(m_last_o), 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int s = 0; s < NS; s++)
                for (int j = 0; j < int'(vecs[v].npk[4*s +: 4]); j++)
                    add_pkt(s, vecs[v].qos[4*s +: 4], int'(vecs[v].len));
            model_build();
            run(0, 20, 3000);
            cmp($sformatf("v%0d_npkts", v), 32'(obs_ids.size()), 32'(vecs[v].nexp));
            for (int i = 0; i < int'(vecs[v].nexp); i++)
                if (i < obs_ids.size())
                    cmp($sformatf("v%0d_id%0d", v, i), 32'(obs_ids[i]), 32'(vecs[v].ids[2*i +: 2]));
        end

        // 8-beat packet with a 5-cycle downstream stall after beat 2
        do_reset();
        add_pkt(0, 4'd3, 8);
        model_build();
        run(2, 0, 500);
        cmp("stall_span", 32'(last_cyc - first_cyc), 32'd12);

        // single stream, full throughput
        do_reset();
        add_pkt(2, 4'd1, 8);
        model_build();
        run(1, 0, 500);
        cmp("thru_span", 32'(last_cyc - first_cyc), 32'd7);

        // reset during beat 4; rr_ptr must restart from 0
        do_reset();
        @(negedge clk);
        s_valid_i = 4'b0100;
        s_qos_i[2] = 4'd5;
        s_data_i[2] = 8'h40;
        m_ready_i = 1'b1;
        #1;
        cmp("lat_idle_sready", 32'(s_ready_o), 32'd0);
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            @(negedge clk);
            s_data_i[2] = 8'h40 + 8'(got);
            #1;
            if (cyc == 0) cmp("lat_gnt_sready", 32'(s_ready_o), 32'h4);
            a = s_ready_o[2];
            @(posedge clk);
            if (a) got++;
            cyc++;
        end
        cmp("rst_mid_beats", 32'(got), 32'd3);
        @(negedge clk);
        #1;
        cmp("rst_mid_pre_valid", 32'(m_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("rst_mid_mvalid", 32'(m_valid_o), 32'd0);
        cmp("rst_mid_sready", 32'(s_ready_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        clear_pkts();
        add_pkt(1, 4'd5, 1);
        add_pkt(3, 4'd5, 1);
        model_build();
        run(1, 0, 200);
        cmp("rst_rr_npkts", 32'(obs_ids.size()), 32'd2);
        if (obs_ids.size() == 2) begin
            cmp("rst_rr_first", 32'(obs_ids[0]), 32'd1);
            cmp("rst_rr_second", 32'(obs_ids[1]), 32'd3);
        end

        // random traffic against the model
        for (int r = 0; r < 24; r++) begin
            do_reset();
            for (int s = 0; s < NS; s++) begin
                int n;
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++)
                    add_pkt(s, (r % 2 == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15)),
                            $urandom_range(1, 5));
            end
            model_build();
            run(0, 25, 3000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
